ram_burst_ctrl: RTL

Burst sequencer directly upstream of the 1K x 8 RAM. It accepts read or write burst commands on a valid/ready interface. It drives the RAM's wr_en/address/data_in with registered signals, one beat per cycle. On reads it returns the RAM's data_out as a valid-qualified byte stream. It replaces hand-sequenced address/wr_en driving of the RAM.

---
 rtl/ram_burst_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port synchronous RAM: turns read/write burst
// commands into registered wr_en/address/data beats and returns read data as a strobed stream.
module ram_burst_ctrl #(
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len_m1,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done
);

    // state    | meaning
    // IDLE     | waiting for a command, cmd_ready high
    // WRITE    | accepting write beats, one RAM write per accepted beat
    // READ     | issuing one read address per cycle
    // DRAIN    | waiting for outstanding read data to return
    // DONE     | one-cycle done pulse, back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CW = AW + 1;

    state_t        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] len_m1_q, len_m1_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          ram_wr_en_q, ram_wr_en_d;
    logic [AW-1:0] ram_address_q, ram_address_d;
    logic [DW-1:0] ram_data_in_q, ram_data_in_d;
    logic [RD_LAT:0] rd_pipe_q, rd_pipe_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic          last_beat;

    assign last_beat = (beat_cnt_q == {1'b0, len_m1_q});

    // Stage 0 of rd_pipe lines up with ram_address; the top stage marks data ready to capture.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        len_m1_d      = len_m1_q;
        beat_cnt_d    = beat_cnt_q;
        ram_wr_en_d   = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        rd_pipe_d     = {rd_pipe_q[RD_LAT-1:0], 1'b0};
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_pipe_q[RD_LAT];
        done_d        = 1'b0;

        if (rd_pipe_q[RD_LAT]) begin
            rd_data_d = ram_data_out;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d = cmd_addr;
                    len_m1_d   = cmd_len_m1;
                    beat_cnt_d = '0;
                    state_d    = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_valid) begin
                    ram_wr_en_d   = 1'b1;
                    ram_address_d = cur_addr_q;
                    ram_data_in_d = wr_data;
                    cur_addr_d    = cur_addr_q + AW'(1);
                    beat_cnt_d    = beat_cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                ram_address_d = cur_addr_q;
                rd_pipe_d[0]  = 1'b1;
                cur_addr_d    = cur_addr_q + AW'(1);
                beat_cnt_d    = beat_cnt_q + CW'(1);
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rd_pipe_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            len_m1_q      <= '0;
            beat_cnt_q    <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            rd_pipe_q     <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            len_m1_q      <= len_m1_d;
            beat_cnt_q    <= beat_cnt_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            rd_pipe_q     <= rd_pipe_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            done_q        <= done_d;
        end
    end

    // cmd_ready is held low while reset is asserted even though the state reads IDLE.
    assign cmd_ready   = (state_q == ST_IDLE) && rst;
    assign wr_ready    = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_address = ram_address_q;
    assign ram_data_in = ram_data_in_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;

endmodule
